// File: rtl/streamer_pkg.sv
// Shared types for the instruction streamer, its CPU and benches.
package streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } streamer_state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_memory.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A read and a write to the same address in one cycle return the old word.
module instruction_memory #(
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_wr_en,
  input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
  input  logic [INSTR_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0]  i_rd_addr,
  output logic [INSTR_WIDTH-1:0] o_rd_data
);

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
  logic [INSTR_WIDTH-1:0] r_rd_data;

  // Write port and registered read port (read sees pre-write contents).
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instruction_streamer.sv
// Program sequencer: issues instructions from a loadable memory to the CPU.
// Pipeline: fetch address -> RAM read register (stage 1) -> output register.
// Handshake: a word transfers on every edge where instruction_valid and
// instruction_ready are both high; while valid is high and ready is low the
// output word, valid and program_counter are held unchanged.
module instruction_streamer
  import streamer_pkg::*;
#(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 1024,
  parameter int                     ADDR_WIDTH  = $clog2(DEPTH),
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = INSTR_WIDTH'(DEFAULT_HALT_WORD),
  parameter int                     COUNT_WIDTH = 32
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   load_enable,
  input  logic [ADDR_WIDTH-1:0]  load_address,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   step,
  input  logic                   stop,
  input  logic                   loop_enable,
  input  logic [ADDR_WIDTH-1:0]  end_address,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   instruction_valid,
  input  logic                   instruction_ready,
  output logic [ADDR_WIDTH-1:0]  program_counter,
  output logic [COUNT_WIDTH-1:0] issued_count,
  output logic [1:0]             state,
  output logic                   halted
);

  streamer_state_t        r_state;
  logic                   r_halted;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_out;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0]  r_fetch_addr;   // next address to read into stage 1
  logic                   r_s1_valid;     // RAM output holds a fetched word
  logic [ADDR_WIDTH-1:0]  r_s1_addr;      // address of the word in stage 1
  logic                   r_step_fetched; // STEP issues exactly one fetch

  logic                   w_active;
  logic                   w_fire;
  logic                   w_end_halt;
  logic                   w_load_out;
  logic                   w_s1_adv;
  logic                   w_is_sentinel;
  logic                   w_wr_en;
  logic [ADDR_WIDTH-1:0]  w_rd_addr;
  logic [INSTR_WIDTH-1:0] w_rd_data;

  // Sequential successor: wraps at end_address when looping, and at the top.
  function automatic logic [ADDR_WIDTH-1:0] f_next_pc(input logic [ADDR_WIDTH-1:0] a);
    if ((loop_enable && (a == end_address)) || (a == ADDR_WIDTH'(DEPTH - 1)))
      return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  assign w_active      = (r_state == RUN) || (r_state == STEP);
  assign w_fire        = r_valid && instruction_ready;
  assign w_end_halt    = w_fire && (r_state == RUN) && (r_pc == end_address) && !loop_enable;
  assign w_load_out    = w_active && !stop && r_s1_valid && (!r_valid || w_fire) && !w_end_halt;
  assign w_is_sentinel = (w_rd_data == HALT_WORD);
  assign w_wr_en       = load_enable && !w_active && !start && !step;

  // Stage 1 advances when empty or when its word moves on; otherwise the same
  // address is re-read so the RAM output holds steady under backpressure.
  always_comb begin
    w_s1_adv = 1'b0;
    if (r_state == RUN)       w_s1_adv = !r_s1_valid || w_load_out;
    else if (r_state == STEP) w_s1_adv = !r_s1_valid && !r_step_fetched;
    w_rd_addr = w_s1_adv ? r_fetch_addr : r_s1_addr;
  end

  instruction_memory #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_mem (
    .i_clk     (clock_in),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (load_address),
    .i_wr_data (load_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Control FSM with fetch pipeline, output register and issue counter.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state        <= IDLE;
      r_halted       <= 1'b0;
      r_pc           <= '0;
      r_out          <= '0;
      r_valid        <= 1'b0;
      r_count        <= '0;
      r_fetch_addr   <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_addr      <= '0;
      r_step_fetched <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (start) begin
            r_state      <= RUN;
            r_halted     <= 1'b0;
            r_pc         <= '0;
            r_count      <= '0;
            r_fetch_addr <= '0;
            r_s1_valid   <= 1'b0;
            r_valid      <= 1'b0;
          end else if (step) begin
            r_state        <= STEP;
            r_halted       <= 1'b0;
            r_fetch_addr   <= r_pc;
            r_s1_valid     <= 1'b0;
            r_step_fetched <= 1'b0;
            r_valid        <= 1'b0;
          end
        end
        RUN, STEP: begin
          if (stop) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_s1_valid <= 1'b0;
          end else begin
            if (w_fire && (r_count != '1)) r_count <= r_count + COUNT_WIDTH'(1);
            if (w_s1_adv) begin
              r_s1_valid     <= 1'b1;
              r_s1_addr      <= r_fetch_addr;
              r_fetch_addr   <= f_next_pc(r_fetch_addr);
              r_step_fetched <= 1'b1;
            end else if (w_load_out) begin
              r_s1_valid <= 1'b0;
            end
            if (w_end_halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
              r_valid  <= 1'b0;
            end else if (w_load_out) begin
              r_pc <= r_s1_addr;
              if (w_is_sentinel) begin
                r_state  <= HALTED;
                r_halted <= 1'b1;
                r_valid  <= 1'b0;
              end else begin
                r_out   <= w_rd_data;
                r_valid <= 1'b1;
              end
            end else if (w_fire) begin
              r_valid <= 1'b0;
              r_pc    <= f_next_pc(r_pc);
              if (r_state == STEP) r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instruction_out   = r_out;
  assign instruction_valid = r_valid;
  assign program_counter   = r_pc;
  assign issued_count      = r_count;
  assign state             = r_state;
  assign halted            = r_halted;

endmodule

// File: tb/tb_instruction_streamer.sv
// Directed bench for instruction_streamer: cycle table plus corner sequences.
module tb_instruction_streamer;

  localparam int IW = 32;
  localparam int AW = 10;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_enable;
  logic [AW-1:0] load_address;
  logic [IW-1:0] load_data;
  logic          start, step, stop, loop_enable, ready;
  logic [AW-1:0] end_address;
  logic [IW-1:0] instruction_out;
  logic          instruction_valid;
  logic [AW-1:0] program_counter;
  logic [CW-1:0] issued_count;
  logic [1:0]    state;
  logic          halted;

  instruction_streamer dut (
    .clock_in          (clk),
    .reset_in          (rst),
    .load_enable       (load_enable),
    .load_address      (load_address),
    .load_data         (load_data),
    .start             (start),
    .step              (step),
    .stop              (stop),
    .loop_enable       (loop_enable),
    .end_address       (end_address),
    .instruction_out   (instruction_out),
    .instruction_valid (instruction_valid),
    .instruction_ready (ready),
    .program_counter   (program_counter),
    .issued_count      (issued_count),
    .state             (state),
    .halted            (halted)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          ready;
    logic          exp_valid;
    logic [IW-1:0] exp_out;
    logic [AW-1:0] exp_pc;
    logic [CW-1:0] exp_cnt;
    logic [1:0]    exp_state;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] prog [4];
  vec_t          vecs [22];

  function automatic vec_t mk(input logic l, input logic s, input logic p, input logic r,
                              input logic v, input logic [IW-1:0] o, input int pc,
                              input int c, input int st);
    vec_t t;
    t.loop_en = l; t.start = s; t.stop = p; t.ready = r; t.exp_valid = v;
    t.exp_out = o; t.exp_pc = AW'(pc); t.exp_cnt = CW'(c); t.exp_state = 2'(st);
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_enable = 1'b1; load_address = a; load_data = d;
    tick();
    load_enable = 1'b0;
  endtask

  task automatic pulse_start(); start = 1'b1; tick(); start = 1'b0; endtask
  task automatic pulse_step();  step  = 1'b1; tick(); step  = 1'b0; endtask
  task automatic pulse_stop();  stop  = 1'b1; tick(); stop  = 1'b0; endtask

  // Scoreboarded issue window: every valid word must match the queue head,
  // and the head is retired on each accepted transfer.
  task automatic issue_window(input string tag, input int cycles, input logic [4:0] pat,
                              input int pat_len);
    for (int i = 0; i < cycles; i++) begin
      ready = (i < pat_len) ? pat[i] : 1'b1;
      if (instruction_valid) begin
        if (exp_q.size() == 0) check({tag, "_extra_issue"}, instruction_valid, 0);
        else begin
          check($sformatf("%s_word%0d", tag, i), instruction_out, exp_q[0]);
          if (ready) void'(exp_q.pop_front());
        end
      end
      tick();
    end
    ready = 1'b1;
  endtask

  // Stimulus and final report
  initial begin
    int lat;
    int n_valid;
    rst = 1'b1; load_enable = 1'b0; load_address = '0; load_data = '0;
    start = 1'b0; step = 1'b0; stop = 1'b0; loop_enable = 1'b0; ready = 1'b1;
    end_address = AW'(3);
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33; prog[3] = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_valid", instruction_valid, 0);
    check("rst_out", instruction_out, 0);
    check("rst_pc", program_counter, 0);
    check("rst_count", issued_count, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    tick();
    check("post_rst_state", state, 0);

    for (int i = 0; i < 4; i++) load_word(AW'(i), prog[i]);

    // Run to end, then loop and stop; one record per clock edge.
    vecs[0]  = mk(0, 1, 0, 1, 0, 32'h00, 0, 0, 1);
    vecs[1]  = mk(0, 0, 0, 1, 0, 32'h00, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 1, 32'h11, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 1, 1, 32'h22, 1, 1, 1);
    vecs[4]  = mk(0, 0, 0, 1, 1, 32'h33, 2, 2, 1);
    vecs[5]  = mk(0, 0, 0, 1, 1, 32'h44, 3, 3, 1);
    vecs[6]  = mk(0, 0, 0, 1, 0, 32'h00, 3, 4, 3);
    vecs[7]  = mk(0, 0, 0, 1, 0, 32'h00, 3, 4, 3);
    vecs[8]  = mk(1, 1, 0, 1, 0, 32'h00, 0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 1, 0, 32'h00, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 1, 1, 32'h11, 0, 0, 1);
    vecs[11] = mk(1, 0, 0, 1, 1, 32'h22, 1, 1, 1);
    vecs[12] = mk(1, 0, 0, 1, 1, 32'h33, 2, 2, 1);
    vecs[13] = mk(1, 0, 0, 1, 1, 32'h44, 3, 3, 1);
    vecs[14] = mk(1, 0, 0, 1, 1, 32'h11, 0, 4, 1);
    vecs[15] = mk(1, 0, 0, 1, 1, 32'h22, 1, 5, 1);
    vecs[16] = mk(1, 0, 0, 1, 1, 32'h33, 2, 6, 1);
    vecs[17] = mk(1, 0, 0, 1, 1, 32'h44, 3, 7, 1);
    vecs[18] = mk(1, 0, 0, 1, 1, 32'h11, 0, 8, 1);
    vecs[19] = mk(1, 0, 0, 1, 1, 32'h22, 1, 9, 1);
    vecs[20] = mk(1, 0, 1, 1, 0, 32'h00, 1, 9, 0);
    vecs[21] = mk(1, 0, 0, 1, 0, 32'h00, 1, 9, 0);

    for (int i = 0; i < 22; i++) begin
      loop_enable = vecs[i].loop_en;
      start       = vecs[i].start;
      stop        = vecs[i].stop;
      ready       = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), instruction_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_out", i), instruction_out, vecs[i].exp_out);
      check($sformatf("vec%0d_pc", i), program_counter, vecs[i].exp_pc);
      check($sformatf("vec%0d_count", i), issued_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d_halted", i), halted, vecs[i].exp_state == 2'd3);
    end
    start = 1'b0; stop = 1'b0; ready = 1'b1;

    // Backpressure: ready 1,0,0,1,1 over the first valid cycles.
    loop_enable = 1'b0;
    exp_q = {32'h11, 32'h22, 32'h33, 32'h44};
    pulse_start();
    tick();
    tick();
    issue_window("bp", 10, 5'b11001, 5);
    check("bp_queue_left", exp_q.size(), 0);
    check("bp_count", issued_count, 4);
    check("bp_state", state, 3);
    check("bp_pc", program_counter, 3);

    // Asynchronous reset between edges during a looping run.
    loop_enable = 1'b1;
    pulse_start();
    repeat (5) tick();
    check("pre_reset_valid", instruction_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", instruction_valid, 0);
    check("async_rst_pc", program_counter, 0);
    check("async_rst_count", issued_count, 0);
    check("async_rst_state", state, 0);
    #2 rst = 1'b0;
    tick();
    check("after_rst_state", state, 0);
    pulse_start();
    lat = 0;
    while (!instruction_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("restart_latency", lat, 2);
    check("restart_first_word", instruction_out, 32'h11);
    pulse_stop();
    check("stop_state", state, 0);
    check("stop_valid", instruction_valid, 0);

    // Single-step from reset: each word exactly once, IDLE in between.
    loop_enable = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      pulse_step();
      n_valid = 0;
      for (int c = 0; c < 5; c++) begin
        if (instruction_valid) begin
          n_valid++;
          check($sformatf("step%0d_word", k), instruction_out, prog[k]);
        end
        tick();
      end
      check($sformatf("step%0d_presented", k), n_valid, 1);
      check($sformatf("step%0d_idle", k), state, 0);
    end
    check("step_pc", program_counter, 3);
    check("step_count", issued_count, 3);

    // Sentinel at address 2 stops issue before it.
    load_word(AW'(0), 32'hA0);
    load_word(AW'(1), 32'hA1);
    load_word(AW'(2), 32'hFFFF_FFFF);
    load_word(AW'(3), 32'hA3);
    exp_q = {32'hA0, 32'hA1};
    pulse_start();
    issue_window("sent", 10, 5'b11111, 0);
    check("sent_queue_left", exp_q.size(), 0);
    check("sent_state", state, 3);
    check("sent_halted", halted, 1);
    check("sent_pc", program_counter, 2);
    check("sent_count", issued_count, 2);
    check("sent_valid", instruction_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
